ft245_fifo_wr_ctrl: RTL and testbench

Write-side controller for the FT245 USB receive path. It drives the FT245 RXF#/RD# read handshake, writes each received byte into the async FIFO's dual-port RAM, and advances the Gray-coded write pointer consumed by the async FIFO comparator. It sits between the FT245 pins and the FIFO write port, entirely in the wclk domain, and stalls on the comparator's `fifo_full`.

---
 rtl/ft245_fifo_wr_ctrl_if.sv | 36 +++
 rtl/ft245_fifo_wr_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ft245_fifo_wr_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft245_fifo_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ft245_fifo_wr_ctrl_if
// Brief   : FT245 read handshake plus async-FIFO write-port bundle for the
//           ft245_fifo_wr_ctrl block.
// Revision: 1.0 - initial release
// ============================================================================
interface ft245_fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    // FT245 pins
    logic                  rxf_n;
    logic [7:0]            ft_data;
    logic                  rd_n;
    // Flow control
    logic                  enable;
    logic                  fifo_full;
    // FIFO write port and status
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [7:0]            ram_wdata;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [15:0]           bytes_written;
    logic                  busy;

    modport master (
        input  rxf_n, ft_data, enable, fifo_full,
        output rd_n, ram_we, ram_waddr, ram_wdata, wptr, bytes_written, busy
    );

    modport slave (
        output rxf_n, ft_data, enable, fifo_full,
        input  rd_n, ram_we, ram_waddr, ram_wdata, wptr, bytes_written, busy
    );
endinterface
`default_nettype wire

// File: rtl/ft245_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ft245_fifo_wr_ctrl
// Brief   : FT245 RXF#/RD# read controller writing received bytes into the
//           async FIFO RAM and advancing the Gray write pointer (wclk domain).
//           Optional macro FT245_DATA_REG_EN adds an input data register.
// Revision: 1.0 - initial release
// ============================================================================
module ft245_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int RD_WAIT    = 3,
    parameter int PRECHARGE  = 2
) (
    input  wire                  wclk,
    input  wire                  direction_clr,
    ft245_fifo_wr_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam int c_cnt_w = 5;

`ifdef FT245_DATA_REG_EN
    localparam int c_strobe_cycles = RD_WAIT + 1;
`else
    localparam int c_strobe_cycles = RD_WAIT;
`endif

    localparam logic [c_cnt_w-1:0] c_strobe_last  = c_cnt_w'(c_strobe_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_recover_last = c_cnt_w'(PRECHARGE - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic                  r_rd_n;
    logic                  w_rd_n_next;
    logic                  w_capture;
    logic                  w_commit;

    logic                  r_rxf_meta;
    logic                  r_rxf_s;

    logic [7:0]            w_capture_data;
    logic                  r_ram_we;
    logic [7:0]            r_ram_wdata;
    logic [ADDR_WIDTH-1:0] r_wbin;
    logic [ADDR_WIDTH-1:0] w_wbin_inc;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [15:0]           r_bytes_written;

    // RXF# is driven by the FT245 clock domain; synchronizer idles "empty".
    always_ff @(posedge wclk or posedge direction_clr) begin
        if (direction_clr) begin
            r_rxf_meta <= 1'b1;
            r_rxf_s    <= 1'b1;
        end else begin
            r_rxf_meta <= bus.rxf_n;
            r_rxf_s    <= r_rxf_meta;
        end
    end

`ifdef FT245_DATA_REG_EN
    logic [7:0] r_ft_data;

    always_ff @(posedge wclk or posedge direction_clr) begin
        if (direction_clr) begin
            r_ft_data <= 8'd0;
        end else begin
            r_ft_data <= bus.ft_data;
        end
    end

    assign w_capture_data = r_ft_data;
`else
    assign w_capture_data = bus.ft_data;
`endif

    always_ff @(posedge wclk or posedge direction_clr) begin
        if (direction_clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd_n  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rd_n  <= w_rd_n_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rd_n_next  = 1'b1;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                // fifo_full and enable only gate the start of a transfer
                if (bus.enable && !r_rxf_s && !bus.fifo_full) begin
                    w_state_next = S_STROBE;
                    w_rd_n_next  = 1'b0;
                end
            end
            S_STROBE: begin
                w_rd_n_next = 1'b0;
                if (r_cnt == c_strobe_last) begin
                    w_state_next = S_CAPTURE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = S_RECOVER;
                w_cnt_next   = '0;
            end
            S_RECOVER: begin
                // Pointer advances only after the RAM write cycle has happened
                w_commit = (r_cnt == '0);
                if (r_cnt == c_recover_last) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_wbin_inc = r_wbin + ADDR_WIDTH'(1);

    always_ff @(posedge wclk or posedge direction_clr) begin
        if (direction_clr) begin
            r_ram_we        <= 1'b0;
            r_ram_wdata     <= 8'd0;
            r_wbin          <= '0;
            r_wptr          <= '0;
            r_bytes_written <= 16'd0;
        end else begin
            r_ram_we <= w_capture;
            if (w_capture) begin
                r_ram_wdata <= w_capture_data;
            end
            if (w_commit) begin
                r_wbin          <= w_wbin_inc;
                r_wptr          <= w_wbin_inc ^ (w_wbin_inc >> 1);
                r_bytes_written <= r_bytes_written + 16'd1;
            end
        end
    end

    assign bus.rd_n          = r_rd_n;
    assign bus.ram_we        = r_ram_we;
    assign bus.ram_waddr     = r_wbin;
    assign bus.ram_wdata     = r_ram_wdata;
    assign bus.wptr          = r_wptr;
    assign bus.bytes_written = r_bytes_written;
    assign bus.busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ft245_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ft245_fifo_wr_ctrl
// Brief   : Self-checking bench: FT245 byte source, reader/comparator model and
//           a write scoreboard driven by randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ft245_fifo_wr_ctrl;
    localparam int AW        = 4;
    localparam int RD_WAIT   = 3;
    localparam int PRECHARGE = 2;
    localparam int c_depth   = 1 << AW;
`ifdef FT245_DATA_REG_EN
    localparam int c_low_w = RD_WAIT + 2;
`else
    localparam int c_low_w = RD_WAIT + 1;
`endif
    localparam int c_period = 1 + c_low_w + PRECHARGE;

    logic wclk;
    logic direction_clr;

    ft245_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    ft245_fifo_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .RD_WAIT    (RD_WAIT),
        .PRECHARGE  (PRECHARGE)
    ) dut (
        .wclk          (wclk),
        .direction_clr (direction_clr),
        .bus           (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int        n_checks;
    int        n_fail;
    int        cyc;
    logic [7:0] src_mem [0:1023];
    int        push_total;
    int        pop_idx;
    int        drain_total;
    int        drain_base;
    int        writes;
    logic [7:0] exp_q [$];
    int        fall_cyc [$];
    int        last_fall;
    bit        pend;
    bit        prev_rd_n = 1'b1;
    bit        rst_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] gray(input int n);
        logic [AW-1:0] b;
        b = AW'(n % c_depth);
        return b ^ (b >> 1);
    endfunction

    function automatic int occ();
        return writes - (drain_total - drain_base);
    endfunction

    always @(posedge wclk) cyc <= cyc + 1;

    // FT245 source, reader/comparator model and write scoreboard
    always @(negedge wclk) begin
        bit  was_pend;
        logic [7:0] exp_b;
        if (direction_clr) begin
            writes     = 0;
            drain_base = drain_total;
            exp_q.delete();
            pend       = 1'b0;
            rst_seen   = 1'b1;
        end
        if (prev_rd_n && !bus.rd_n) begin
            check("rd_when_empty", 32'(pop_idx < push_total), 1);
            check("busy_in_read", 32'(bus.busy), 1);
            if (!rst_seen && fall_cyc.size() > 0)
                check("rd_gap_min", 32'((cyc - last_fall) >= c_period), 1);
            fall_cyc.push_back(cyc);
            last_fall = cyc;
            rst_seen  = 1'b0;
        end
        if (!prev_rd_n && bus.rd_n) begin
            pop_idx++;
            if (!direction_clr && !rst_seen) begin
                check("rd_low_width", 32'(cyc - last_fall), 32'(c_low_w));
                exp_q.push_back(src_mem[pop_idx-1]);
            end
        end
        was_pend = pend;
        if (pend) begin
            pend = 1'b0;
            check("we_one_cycle", 32'(bus.ram_we), 0);
            check("wptr_gray", 32'(bus.wptr), 32'(gray(writes)));
            check("bytes_written", 32'(bus.bytes_written), 32'(writes % 65536));
        end
        if (bus.ram_we && !was_pend) begin
            check("we_expected", 32'(exp_q.size() > 0), 1);
            check("no_overflow", 32'(occ() < c_depth), 1);
            check("waddr", 32'(bus.ram_waddr), 32'(writes % c_depth));
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("wdata", 32'(bus.ram_wdata), 32'(exp_b));
            end
            writes++;
            pend = 1'b1;
        end
        bus.rxf_n     = !(pop_idx < push_total);
        bus.ft_data   = (!bus.rd_n && pop_idx < push_total) ? src_mem[pop_idx] : 8'($urandom);
        bus.fifo_full = (occ() >= c_depth);
        prev_rd_n     = bus.rd_n;
    end

    task automatic push_byte(input logic [7:0] b);
        src_mem[push_total] = b;
        push_total++;
    endtask

    task automatic wait_rd_fall(input string tag, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(posedge wclk); #1;
            if (!bus.rd_n) break;
        end
        check({tag, "_rd_seen"}, 32'(i < max_cyc), 1);
    endtask

    task automatic drain_all(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge wclk); #1;
            if (occ() > 0) drain_total++;
            if (pop_idx == push_total && occ() == 0 && bus.rd_n && !bus.busy && exp_q.size() == 0)
                break;
        end
        check({tag, "_drained"}, 32'(i < 3000), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb;
        int w0;
        direction_clr = 1'b1;
        bus.enable    = 1'b1;
        repeat (3) @(posedge wclk);
        #1 direction_clr = 1'b0;

        check("rst_rd_n", 32'(bus.rd_n), 1);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_waddr", 32'(bus.ram_waddr), 0);
        check("rst_wdata", 32'(bus.ram_wdata), 0);
        check("rst_wptr", 32'(bus.wptr), 0);
        check("rst_bytes", 32'(bus.bytes_written), 0);
        check("rst_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 100; i++) begin
            @(posedge wclk); #1;
            check("idle_rd_n", 32'(bus.rd_n), 1);
        end

        // Single byte: RD# low exactly at the third edge after RXF# falls
        @(posedge wclk); #1 push_byte(8'hA5);
        repeat (2) @(posedge wclk);
        #1 check("rd_edge2", 32'(bus.rd_n), 1);
        @(posedge wclk);
        #1 check("rd_edge3", 32'(bus.rd_n), 0);
        repeat (20) @(posedge wclk);
        #1;
        check("single_writes", 32'(writes), 1);
        check("single_bytes", 32'(bus.bytes_written), 1);
        check("single_wptr", 32'(bus.wptr), 1);

        // Back-to-back until the comparator reports full
        @(posedge wclk); #1 direction_clr = 1'b1;
        @(negedge wclk);
        @(posedge wclk); #1 direction_clr = 1'b0;
        fb = fall_cyc.size();
        for (int i = 0; i < 20; i++) push_byte(8'($urandom));
        repeat (200) @(posedge wclk);
        #1;
        check("full_writes", 32'(writes), 16);
        check("full_bytes", 32'(bus.bytes_written), 16);
        check("full_rd_idle", 32'(bus.rd_n), 1);
        check("full_flag", 32'(bus.fifo_full), 1);
        check("full_reads", 32'(fall_cyc.size() - fb), 16);
        for (int k = 1; k < 16 && fb + k < fall_cyc.size(); k++)
            check("b2b_period", 32'(fall_cyc[fb+k] - fall_cyc[fb+k-1]), 32'(c_period));
        drain_total++;
        repeat (40) @(posedge wclk);
        #1;
        check("drain1_writes", 32'(writes), 17);
        check("drain1_reads", 32'(fall_cyc.size() - fb), 17);
        drain_all("full");

        // Reset during STROBE
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wait_rd_fall("rst", 50);
        @(posedge wclk); #2 direction_clr = 1'b1;
        #1;
        check("rst_async_rd_n", 32'(bus.rd_n), 1);
        check("rst_async_wptr", 32'(bus.wptr), 0);
        check("rst_async_we", 32'(bus.ram_we), 0);
        @(negedge wclk);
        @(posedge wclk); #1 direction_clr = 1'b0;
        repeat (2) @(posedge wclk);
        #1 check("resume_edge2", 32'(bus.rd_n), 1);
        @(posedge wclk);
        #1 check("resume_edge3", 32'(bus.rd_n), 0);
        drain_all("rst");

        // Enable dropped during CAPTURE
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wait_rd_fall("en", 50);
        w0 = writes;
        repeat (c_low_w - 1) @(posedge wclk);
        #1 bus.enable = 1'b0;
        check("en_capture_rd_n", 32'(bus.rd_n), 0);
        repeat (40) @(posedge wclk);
        #1;
        check("en_writes", 32'(writes), 32'(w0 + 1));
        check("en_bytes", 32'(bus.bytes_written), 32'(w0 + 1));
        check("en_idle_rd_n", 32'(bus.rd_n), 1);
        check("en_idle_busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;
        wait_rd_fall("en_resume", 20);
        drain_all("en");

        // Randomized traffic with reader and enable activity
        for (int i = 0; i < 800; i++) begin
            @(posedge wclk); #1;
            if ($urandom_range(0, 7) == 0 && push_total < 1000 && push_total - pop_idx < 8)
                push_byte(8'($urandom));
            if ($urandom_range(0, 5) == 0 && occ() > 0)
                drain_total++;
            if ($urandom_range(0, 29) == 0)
                bus.enable = ($urandom_range(0, 3) != 0);
        end
        bus.enable = 1'b1;
        drain_all("rand");
        check("final_all_popped", 32'(pop_idx), 32'(push_total));
        check("final_bytes", 32'(bus.bytes_written), 32'(writes % 65536));
        check("final_wptr", 32'(bus.wptr), 32'(gray(writes)));
        check("final_exp_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
